// File: rtl/dram_sched_buffer.sv
// Ordered request buffer ahead of the DRAM command generator.
// It maps the head and next addresses to DRAM coordinates, returns responses and times refreshes.
module dram_sched_buffer #(
    parameter int DEPTH = 8,
    parameter int tREFI = 6240
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_wen,
    output logic [31:0] resp_rdata,
    output logic [2:0]  Ra0,
    output logic [2:0]  Ra1,
    output logic [1:0]  BG0,
    output logic [1:0]  BG1,
    output logic [1:0]  BA0,
    output logic [1:0]  BA1,
    output logic [17:0] R0,
    output logic [17:0] R1,
    output logic [13:0] COL0,
    output logic [13:0] COL1,
    output logic        ramREN_curr,
    output logic        ramWEN_curr,
    output logic        ramREN_ftrt,
    output logic        ramWEN_ftrt,
    output logic [31:0] write_data,
    input  logic        request_done,
    input  logic [31:0] data_callback,
    output logic        REFRESH,
    input  logic        refresh_ack
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(tREFI);
    localparam logic [CW-1:0] CNT_MAX = CW'(tREFI - 1);

    typedef enum logic {COUNT, PEND} ref_state_e;

    // Byte offset is never stored; the DRAM beat is word addressed.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    logic [31:2] addr_q  [DEPTH];
    logic [31:0] wdata_q [DEPTH];
    logic        wen_q   [DEPTH];

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] count_w;
    logic        empty_w, full_w, push_w, pop_w;

    assign empty_w  = (wptr_q == rptr_q);
    assign full_w   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign count_w  = wptr_q - rptr_q;
    assign push_w   = req_valid && !full_w;
    assign pop_w    = request_done && !empty_w;
    assign req_ready = !full_w;

    assign wptr_d = wptr_q + {{AW{1'b0}}, push_w};
    assign rptr_d = rptr_q + {{AW{1'b0}}, pop_w};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                wen_q[i]   <= 1'b0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (push_w) begin
                addr_q[wptr_q[AW-1:0]]  <= req_addr[31:2];
                wdata_q[wptr_q[AW-1:0]] <= req_wdata;
                wen_q[wptr_q[AW-1:0]]   <= req_wen;
            end
        end
    end

    // Slot 0 is the head, slot 1 the entry behind it; both read straight from storage.
    logic [AW-1:0] slot_idx   [2];
    logic [31:2]   slot_addr  [2];
    logic          slot_wen   [2];
    logic [31:0]   slot_wdata [2];
    logic          slot_vld   [2];
    logic [2:0]    slot_ra    [2];
    logic [1:0]    slot_bg    [2];
    logic [1:0]    slot_ba    [2];
    logic [17:0]   slot_row   [2];
    logic [13:0]   slot_col   [2];

    assign slot_idx[0] = rptr_q[AW-1:0];
    assign slot_idx[1] = rptr_q[AW-1:0] + 1'b1;
    assign slot_vld[0] = !empty_w;
    assign slot_vld[1] = (count_w >= (AW+1)'(2));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_addr[gi]  = addr_q[slot_idx[gi]];
            assign slot_wen[gi]   = wen_q[slot_idx[gi]];
            assign slot_wdata[gi] = wdata_q[slot_idx[gi]];
            assign slot_ra[gi]    = {2'b00, slot_addr[gi][31]};
            assign slot_row[gi]   = {3'b000, slot_addr[gi][30:16]};
            assign slot_ba[gi]    = slot_addr[gi][15:14];
            assign slot_bg[gi]    = {slot_addr[gi][13], slot_addr[gi][5]};
            assign slot_col[gi]   = {4'b0000, slot_addr[gi][12:6], slot_addr[gi][4:2]};
        end
    endgenerate

    assign Ra0  = slot_ra[0];
    assign Ra1  = slot_ra[1];
    assign BG0  = slot_bg[0];
    assign BG1  = slot_bg[1];
    assign BA0  = slot_ba[0];
    assign BA1  = slot_ba[1];
    assign R0   = slot_row[0];
    assign R1   = slot_row[1];
    assign COL0 = slot_col[0];
    assign COL1 = slot_col[1];
    assign ramREN_curr = slot_vld[0] && !slot_wen[0];
    assign ramWEN_curr = slot_vld[0] &&  slot_wen[0];
    assign ramREN_ftrt = slot_vld[1] && !slot_wen[1];
    assign ramWEN_ftrt = slot_vld[1] &&  slot_wen[1];
    assign write_data  = slot_wdata[0];

    logic        resp_valid_q;
    logic        resp_wen_q;
    logic [31:0] resp_rdata_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            resp_valid_q <= 1'b0;
            resp_wen_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= pop_w;
            resp_wen_q   <= pop_w && slot_wen[0];
            resp_rdata_q <= (pop_w && !slot_wen[0]) ? data_callback : 32'h0;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_wen   = resp_wen_q;
    assign resp_rdata = resp_rdata_q;

    ref_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          refresh_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= COUNT;
            cnt_q     <= '0;
            refresh_q <= 1'b0;
        end else begin
            case (state_q)
                COUNT: begin
                    if (cnt_q == CNT_MAX) begin
                        state_q   <= PEND;
                        cnt_q     <= '0;
                        refresh_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PEND: begin
                    if (refresh_ack) begin
                        state_q   <= COUNT;
                        refresh_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= COUNT;
                    cnt_q     <= '0;
                    refresh_q <= 1'b0;
                end
            endcase
        end
    end

    assign REFRESH = refresh_q;

endmodule
